bus_block_master: RTL and testbench

- Hardware bus initiator for the memory-mapped master port of the top-level system (M_req/M_wr/M_address/M_dout in, M_grant/M_din out).
- It drives that port from the initiator side. On a start pulse it writes a block of N pattern words to consecutive addresses, reads the same block back, and compares each word.
- It reports done, error count and first failing address.
- It replaces bench-driven memory fill/readback in system-level self-test.

---
 rtl/bus_block_master.sv | 189 ++++++++++++++++++
 tb/tb_bus_block_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_block_master.sv
// Bus initiator self-test: writes a seeded incrementing block, reads it back and
// compares each word, reporting done, a saturating error count and the first failing address.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; bus request low
// S_WRITE | issuing write beats base+i <- seed+i, i = 0..N-1
// S_READ  | issuing read beats base+i, compare scheduled for next cycle
// S_CHECK | bus released; completing the last pending compare
// S_DONE  | one-cycle done pulse, then back to idle
module bus_block_master #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   length,
   input  logic [DW-1:0] seed,
   output logic          M_req,
   output logic          M_wr,
   output logic [AW-1:0] M_address,
   output logic [DW-1:0] M_dout,
   input  logic          M_grant,
   input  logic [DW-1:0] M_din,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] first_err_addr
);

   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [DW-1:0] D_ONE = DW'(1);
   localparam logic [AW:0]   C_ONE = (AW+1)'(1);
   localparam logic [AW:0]   C_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic [AW-1:0] last_idx;
   logic [AW-1:0] base_q;
   logic [DW-1:0] seed_q;
   logic [DW-1:0] pat;

   logic          pend;
   logic [DW-1:0] pend_exp;
   logic [AW-1:0] pend_addr;

   logic beat_ok;
   logic is_last;
   logic clr_stats;
   logic rd_accept;
   logic mismatch;

   assign beat_ok   = M_req && M_grant;
   assign is_last   = (idx == last_idx);
   assign clr_stats = (state == S_IDLE) && start;
   assign rd_accept = (state == S_READ) && beat_ok;
   assign mismatch  = pend && (M_din != pend_exp);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         last_idx  <= '0;
         base_q    <= '0;
         seed_q    <= '0;
         pat       <= '0;
         M_req     <= 1'b0;
         M_wr      <= 1'b0;
         M_address <= '0;
         M_dout    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     base_q    <= base_addr;
                     seed_q    <= seed;
                     // length 256 has zero low bits, so last index wraps to 8'hFF
                     last_idx  <= length[AW-1:0] - A_ONE;
                     idx       <= '0;
                     pat       <= seed;
                     M_address <= base_addr;
                     M_dout    <= seed;
                     M_wr      <= 1'b1;
                     M_req     <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_WRITE;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_WRITE: begin
               if (beat_ok) begin
                  if (is_last) begin
                     idx       <= '0;
                     pat       <= seed_q;
                     M_address <= base_q;
                     M_dout    <= '0;
                     M_wr      <= 1'b0;
                     state     <= S_READ;
                  end else begin
                     idx       <= idx + A_ONE;
                     pat       <= pat + D_ONE;
                     M_address <= M_address + A_ONE;
                     M_dout    <= pat + D_ONE;
                  end
               end
            end
            S_READ: begin
               if (beat_ok) begin
                  if (is_last) begin
                     M_req <= 1'b0;
                     state <= S_CHECK;
                  end else begin
                     idx       <= idx + A_ONE;
                     pat       <= pat + D_ONE;
                     M_address <= M_address + A_ONE;
                  end
               end
            end
            S_CHECK: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               // a zero-length request arrives here without the pulse raised yet
               if (done) begin
                  state <= S_IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               M_req <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend           <= 1'b0;
         pend_exp       <= '0;
         pend_addr      <= '0;
         err            <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (clr_stats) begin
         pend           <= 1'b0;
         err            <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         if (mismatch) begin
            err <= 1'b1;
            if (err_count != C_MAX) begin
               err_count <= err_count + C_ONE;
            end
            if (!err) begin
               first_err_addr <= pend_addr;
            end
         end
         pend <= rd_accept;
         if (rd_accept) begin
            pend_exp  <= pat;
            pend_addr <= M_address;
         end
      end
   end

endmodule

// File: tb/tb_bus_block_master.sv
// Scoreboard bench for bus_block_master: expected bus beats and completion results are
// queued at stimulus time and checked by a monitor whenever the DUT presents a beat or done.
module tb_bus_block_master;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] seed = '0;
   logic          M_req;
   logic          M_wr;
   logic [AW-1:0] M_address;
   logic [DW-1:0] M_dout;
   logic          M_grant = 1'b1;
   logic [DW-1:0] M_din = '0;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr;

   always #5 clk = ~clk;

   bus_block_master #(.AW(AW), .DW(DW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .seed           (seed),
      .M_req          (M_req),
      .M_wr           (M_wr),
      .M_address      (M_address),
      .M_dout         (M_dout),
      .M_grant        (M_grant),
      .M_din          (M_din),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model standing in for the top-level slave side
   logic [DW-1:0] mem [256];
   logic corrupt_en = 1'b0;
   always @(posedge clk) begin
      if (M_req && M_grant) begin
         if (M_wr) mem[M_address] <= M_dout;
         else if (corrupt_en && (M_address == 8'h05 || M_address == 8'h09)) M_din <= 32'hDEAD;
         else M_din <= mem[M_address];
      end
   end

   // grant driver: optional stalls of 3 cycles at write 8'h07 and 2 cycles at read 8'h10
   logic stall_en = 1'b0;
   int   wst = 0;
   int   rsc = 0;
   always @(posedge clk) begin
      #2;
      if (!stall_en) begin
         wst = 0;
         rsc = 0;
         M_grant = 1'b1;
      end else if (M_req && M_wr && M_address == 8'h07 && wst < 3) begin
         M_grant = 1'b0;
         wst++;
      end else if (M_req && !M_wr && M_address == 8'h10 && rsc < 2) begin
         M_grant = 1'b0;
         rsc++;
      end else begin
         M_grant = 1'b1;
      end
   end

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      int            t0;
      int            lat;
      logic          err;
      logic [AW:0]   cnt;
      logic [AW-1:0] first;
   } res_t;

   beat_t beat_q[$];
   res_t  res_q[$];

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic monitor();
      beat_t b;
      res_t  r;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (M_req && M_grant) begin
               if (beat_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual wr=%0d addr=%0h expected no beat", M_wr, M_address);
               end else begin
                  b = beat_q.pop_front();
                  check("beat_wr", 64'(M_wr), 64'(b.wr));
                  check("beat_addr", 64'(M_address), 64'(b.addr));
                  check("beat_dout", 64'(M_dout), 64'(b.data));
               end
            end else if (M_req && beat_q.size() != 0) begin
               check("stall_hold_addr", 64'(M_address), 64'(beat_q[0].addr));
               check("stall_hold_dout", 64'(M_dout), 64'(beat_q[0].data));
            end
            if (done) begin
               if (res_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=1 expected=0");
               end else begin
                  r = res_q.pop_front();
                  check("done_latency", 64'(cyc - r.t0), 64'(r.lat));
                  check("done_err", 64'(err), 64'(r.err));
                  check("done_err_count", 64'(err_count), 64'(r.cnt));
                  check("done_first_err_addr", 64'(first_err_addr), 64'(r.first));
                  check("done_busy_low", 64'(busy), 64'd0);
                  check("done_req_low", 64'(M_req), 64'd0);
               end
            end
         end
      end
   endtask

   task automatic run(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                      input int lat, input logic e, input logic [AW:0] c, input logic [AW-1:0] f);
      res_t r;
      beat_t bt;
      for (int i = 0; i < n; i++) begin
         bt.wr = 1'b1;
         bt.addr = AW'(b + AW'(i));
         bt.data = DW'(s + DW'(i));
         beat_q.push_back(bt);
      end
      for (int i = 0; i < n; i++) begin
         bt.wr = 1'b0;
         bt.addr = AW'(b + AW'(i));
         bt.data = '0;
         beat_q.push_back(bt);
      end
      @(posedge clk);
      #1;
      base_addr = b;
      length = (AW+1)'(n);
      seed = s;
      start = 1'b1;
      r.t0 = cyc + 1;
      r.lat = lat;
      r.err = e;
      r.cnt = c;
      r.first = f;
      res_q.push_back(r);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (k < 2000 && (beat_q.size() != 0 || res_q.size() != 0)) begin
         @(posedge clk);
         k++;
      end
      if (beat_q.size() != 0 || res_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s actual beats_left=%0d results_left=%0d expected 0", name,
                  beat_q.size(), res_q.size());
         beat_q.delete();
         res_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_M_req"}, 64'(M_req), 64'd0);
      check({tag, "_M_wr"}, 64'(M_wr), 64'd0);
      check({tag, "_M_address"}, 64'(M_address), 64'd0);
      check({tag, "_M_dout"}, 64'(M_dout), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_err_count"}, 64'(err_count), 64'd0);
      check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
   endtask

   initial begin
      int  k;
      logic found;
      fork
         monitor();
      join_none

      #2 reset_n = 1'b0;
      #1 check_zero("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // always-grant fill and readback
      run(8'h00, 32, 32'h0, 65, 1'b0, '0, '0);
      wait_idle("always_grant");

      // grant stalls in both phases
      stall_en = 1'b1;
      run(8'h00, 32, 32'h0, 70, 1'b0, '0, '0);
      wait_idle("stall");
      stall_en = 1'b0;

      // two corrupted read words
      corrupt_en = 1'b1;
      run(8'h00, 32, 32'h0, 65, 1'b1, 9'd2, 8'h05);
      wait_idle("corrupt");
      corrupt_en = 1'b0;

      // address and data wrap
      run(8'hFE, 4, 32'hFFFF_FFFF, 9, 1'b0, '0, '0);
      wait_idle("wrap");

      // zero length: no beats, done one cycle after start
      run(8'h30, 0, 32'h9, 1, 1'b0, '0, '0);
      wait_idle("zero_len");

      // second start mid-burst is ignored
      run(8'h40, 8, 32'h100, 17, 1'b0, '0, '0);
      repeat (4) @(posedge clk);
      #1;
      check("busy_mid_burst", 64'(busy), 64'd1);
      base_addr = 8'h80;
      length = 9'd3;
      seed = 32'h777;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("ignored_start");

      // asynchronous reset during the read phase at 8'h0C
      run(8'h00, 16, 32'h500, 33, 1'b0, '0, '0);
      found = 1'b0;
      k = 0;
      while (k < 200 && !found) begin
         @(posedge clk);
         #3;
         if (M_req && !M_wr && M_address == 8'h0C) found = 1'b1;
         k++;
      end
      check("reach_read_0c", 64'(found), 64'd1);
      reset_n = 1'b0;
      #1 check_zero("midreset");
      beat_q.delete();
      res_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      run(8'h20, 2, 32'h7, 5, 1'b0, '0, '0);
      wait_idle("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
